// File: rtl/controller_warn_pwm_sequencer_if.sv
// Avalon-MM slave port of the warning-indicator PWM sequencer.
// The master side is the controller's bus; the slave side is the sequencer.
interface controller_warn_pwm_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/controller_warn_pwm_sequencer.sv
// Warning-indicator PWM sequencer: four software-selectable modes (off, solid,
// blink, breathe). The per-frame level changes only at frame boundaries, so
// the PWM waveform never shows a runt pulse mid-frame.
module controller_warn_pwm_sequencer #(
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  controller_warn_pwm_sequencer_if.slave       bus,
  output logic                                 pwm_out,
  output logic                                 active
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOLID,
    ST_BLINK_ON,
    ST_BLINK_OFF,
    ST_RAMP_UP,
    ST_RAMP_DOWN
  } state_e;

  // Software-visible registers
  mode_e                    mode_q, mode_d;
  logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;
  logic [PWM_BITS-1:0]      duty_q, duty_d;
  logic [7:0]               blink_on_q, blink_on_d;
  logic [7:0]               blink_off_q, blink_off_d;

  // Timebase
  logic [PRESCALE_BITS-1:0] pcnt_q, pcnt_d;
  logic [PWM_BITS-1:0]      cnt_q, cnt_d;
  logic                     tick;
  logic                     frame_end;

  // Frame-rate sequencer
  state_e                   state_q, state_d;
  mode_e                    run_mode_q, run_mode_d;
  logic [7:0]               fcnt_q, fcnt_d;
  logic [PWM_BITS-1:0]      ramp_q, ramp_d;
  logic [PWM_BITS-1:0]      level_q, level_d;

  // Outputs
  logic                     pwm_q, pwm_d;
  logic                     active_q, active_d;

  logic                     wr_en;
  logic                     unused_wdata;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign unused_wdata = ^bus.writedata[31:16];

  // Register writes: only the addressed field changes, upper bits are dropped.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mode_d      = mode_q;
    prescale_d  = prescale_q;
    duty_d      = duty_q;
    blink_on_d  = blink_on_q;
    blink_off_d = blink_off_q;
    if (wr_en) begin
      unique case (bus.address)
        2'd0: mode_d      = mode_e'(bus.writedata[1:0]);
        2'd1: prescale_d  = bus.writedata[PRESCALE_BITS-1:0];
        2'd2: duty_d      = bus.writedata[PWM_BITS-1:0];
        2'd3: begin
          blink_on_d  = bus.writedata[7:0];
          blink_off_d = bus.writedata[15:8];
        end
        default: ;
      endcase
    end
  end

  // Combinational readback of the addressed register, zero-extended.
  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      2'd0: bus.readdata = 32'(mode_q);
      2'd1: bus.readdata = 32'(prescale_q);
      2'd2: bus.readdata = 32'(duty_q);
      2'd3: bus.readdata = {16'h0000, blink_off_q, blink_on_q};
      default: ;
    endcase
  end

  // Register file state.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      mode_q      <= MODE_BLINK;
      prescale_q  <= PRESCALE_BITS'(99);
      duty_q      <= '1;
      blink_on_q  <= 8'h1F;
      blink_off_q <= 8'h1F;
    end else begin
      mode_q      <= mode_d;
      prescale_q  <= prescale_d;
      duty_q      <= duty_d;
      blink_on_q  <= blink_on_d;
      blink_off_q <= blink_off_d;
    end
  end

  // Prescaler and PWM counter. Using >= lets a lowered PRESCALE tick at once.
  always_comb begin
    tick      = (pcnt_q >= prescale_q);
    pcnt_d    = tick ? '0 : pcnt_q + 1'b1;
    cnt_d     = tick ? cnt_q + 1'b1 : cnt_q;
    frame_end = tick && (cnt_q == '1);
  end

  // Timebase counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      cnt_q  <= cnt_d;
    end
  end

  // Sequencer next state: everything moves only at frame_end; a mode change
  // restarts from the new mode's entry state. level is for the frame entered.
  always_comb begin
    state_d    = state_q;
    run_mode_d = run_mode_q;
    fcnt_d     = fcnt_q;
    ramp_d     = ramp_q;
    level_d    = level_q;
    if (frame_end) begin
      if (mode_q != run_mode_q) begin
        run_mode_d = mode_q;
        fcnt_d     = '0;
        ramp_d     = '0;
        case (mode_q)
          MODE_OFF:   state_d = ST_IDLE;
          MODE_SOLID: state_d = ST_SOLID;
          MODE_BLINK: state_d = ST_BLINK_ON;
          default:    state_d = ST_RAMP_UP;
        endcase
      end else begin
        case (state_q)
          ST_BLINK_ON: begin
            if (fcnt_q >= blink_on_q) begin
              state_d = ST_BLINK_OFF;
              fcnt_d  = '0;
            end else begin
              fcnt_d  = fcnt_q + 8'd1;
            end
          end
          ST_BLINK_OFF: begin
            if (fcnt_q >= blink_off_q) begin
              state_d = ST_BLINK_ON;
              fcnt_d  = '0;
            end else begin
              fcnt_d  = fcnt_q + 8'd1;
            end
          end
          ST_RAMP_UP: begin
            // Also clamps when DUTY was lowered below the current ramp.
            if (ramp_q >= duty_q) begin
              ramp_d  = duty_q;
              state_d = ST_RAMP_DOWN;
            end else begin
              ramp_d  = ramp_q + 1'b1;
            end
          end
          ST_RAMP_DOWN: begin
            if (ramp_q == '0) state_d = ST_RAMP_UP;
            else              ramp_d  = ramp_q - 1'b1;
          end
          default: ;
        endcase
      end
      case (state_d)
        ST_SOLID, ST_BLINK_ON:   level_d = duty_q;
        ST_RAMP_UP, ST_RAMP_DOWN: level_d = ramp_d;
        default:                 level_d = '0;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_BLINK_ON;
      run_mode_q <= MODE_BLINK;
      fcnt_q     <= '0;
      ramp_q     <= '0;
      level_q    <= '1;
    end else begin
      state_q    <= state_d;
      run_mode_q <= run_mode_d;
      fcnt_q     <= fcnt_d;
      ramp_q     <= ramp_d;
      level_q    <= level_d;
    end
  end

  // PWM compare; full scale forces a solid 1 so there is no one-tick gap.
  always_comb begin
    pwm_d    = (level_q == '1) || (cnt_q < level_q);
    active_d = (run_mode_q != MODE_OFF);
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      pwm_q    <= pwm_d;
      active_q <= active_d;
    end
  end

  assign pwm_out = pwm_q;
  assign active  = active_q;

endmodule

// File: tb/tb_controller_warn_pwm_sequencer.sv
// Bench for the warning PWM sequencer: directed register programming, an
// abstract per-frame model checked against pwm_out/active every cycle, and
// hand-computed run lengths, per-frame duty counts and readback values.
module tb_controller_warn_pwm_sequencer;

  logic clk;
  logic reset_n;
  logic pwm_out;
  logic active;

  controller_warn_pwm_sequencer_if bus ();

  controller_warn_pwm_sequencer #(.PWM_BITS(8), .PRESCALE_BITS(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .pwm_out (pwm_out),
    .active  (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Timebase in plain integers; per-frame level from a mode description:
  // blink as a frame index modulo its period, breathe as ramp plus direction.
  int   m_pcnt, m_cnt, m_prescale, m_duty, m_on, m_off;
  int   m_mode, m_run_mode, m_level, m_blink_n, m_ramp, m_frames;
  bit   m_up;
  logic exp_pwm, exp_active;

  task automatic model_reset();
    m_pcnt = 0; m_cnt = 0; m_prescale = 99; m_duty = 255; m_on = 31; m_off = 31;
    m_mode = 2; m_run_mode = 2; m_level = 255; m_blink_n = 0; m_ramp = 0; m_up = 1;
    exp_pwm = 1'b0; exp_active = 1'b0;
  endtask

  task automatic model_frame();
    if (m_mode != m_run_mode) begin
      m_run_mode = m_mode; m_blink_n = 0; m_ramp = 0; m_up = 1;
    end else if (m_run_mode == 2) begin
      m_blink_n++;
    end else if (m_run_mode == 3) begin
      if (m_up) begin
        if (m_ramp >= m_duty) begin m_ramp = m_duty; m_up = 0; end
        else m_ramp++;
      end else begin
        if (m_ramp == 0) m_up = 1;
        else m_ramp--;
      end
    end
    case (m_run_mode)
      0: m_level = 0;
      1: m_level = m_duty;
      2: m_level = ((m_blink_n % (m_on + m_off + 2)) < (m_on + 1)) ? m_duty : 0;
      default: m_level = m_ramp;
    endcase
  endtask

  task automatic model_write(input logic [1:0] a, input logic [31:0] d);
    case (a)
      2'd0: m_mode = int'(d[1:0]);
      2'd1: m_prescale = int'(d[15:0]);
      2'd2: m_duty = int'(d[7:0]);
      default: begin m_on = int'(d[7:0]); m_off = int'(d[15:8]); end
    endcase
  endtask

  task automatic model_step();
    logic tick;
    logic fe;
    exp_pwm    = (m_level == 255) || (m_cnt < m_level);
    exp_active = (m_run_mode != 0);
    tick = (m_pcnt >= m_prescale);
    fe   = tick && (m_cnt == 255);
    m_pcnt = tick ? 0 : m_pcnt + 1;
    if (tick) m_cnt = (m_cnt + 1) % 256;
    if (fe) begin
      model_frame();
      m_frames++;
    end
    if (bus.chipselect && !bus.write_n) model_write(bus.address, bus.writedata);
  endtask

  initial begin
    m_frames = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("pwm_model", pwm_out, exp_pwm);
      check("active_model", active, exp_active);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.address = a;
    #1;
    check(name, bus.readdata, exp);
  endtask

  task automatic wait_boundary(input string name);
    int start;
    int n;
    start = m_frames;
    n = 0;
    while (m_frames == start && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (m_frames == start) timeout(name);
  endtask

  task automatic wait_level(input logic val, input string name);
    int n;
    n = 0;
    while (pwm_out !== val && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (pwm_out !== val) timeout(name);
  endtask

  task automatic run_len(input logic val, output int len);
    len = 0;
    while (pwm_out === val && len < 20000) begin
      @(negedge clk);
      len++;
    end
  endtask

  // Counts high cycles over one 256-clock frame (PRESCALE = 0), starting at a
  // frame boundary; the one-clock output register delay lines up exactly.
  task automatic measure_frame(output int highs);
    highs = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_out) highs++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int len;
    int h;
    int n;
    int exp_breathe[10];
    int exp_clamp[4];
    exp_breathe = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1};
    exp_clamp   = '{1, 0, 0, 1};

    reset_n = 1'b0;
    bus.address = 2'd0; bus.writedata = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pwm", pwm_out, 1'b0);
    check("reset_active", active, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("first_pwm", pwm_out, 1'b1);
    check("first_active", active, 1'b1);
    read_check("rd_mode_rst", 2'd0, 32'd2);
    read_check("rd_prescale_rst", 2'd1, 32'd99);
    read_check("rd_duty_rst", 2'd2, 32'd255);
    read_check("rd_blink_rst", 2'd3, 32'h1F1F);

    // Default blink: 32 frames on, 32 frames off at 256 clocks per frame.
    bus_write(2'd1, 32'd0);
    wait_level(1'b0, "reset_blink_fall");
    run_len(1'b0, len);
    check("reset_off_run", len, 32'd8192);
    run_len(1'b1, len);
    check("reset_on_run", len, 32'd8192);

    // SOLID duty sweep.
    bus_write(2'd2, 32'd64);
    bus_write(2'd0, 32'd1);
    read_check("rd_mode_solid", 2'd0, 32'd1);
    wait_boundary("solid64_frame");
    measure_frame(h);
    check("solid64_highs", h, 32'd64);
    bus_write(2'd2, 32'd255);
    wait_boundary("solid255_frame");
    measure_frame(h);
    check("solid255_highs", h, 32'd256);
    bus_write(2'd2, 32'd0);
    wait_boundary("solid0_frame");
    measure_frame(h);
    check("solid0_highs", h, 32'd0);

    // Mid-frame DUTY write must not disturb the running frame.
    bus_write(2'd2, 32'd200);
    wait_boundary("mid_frame_sync");
    n = 0;
    while (m_cnt != 50 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (m_cnt != 50) timeout("mid_cnt50");
    bus_write(2'd2, 32'd10);
    repeat (3) @(negedge clk);
    check("mid_frame_hold", pwm_out, 1'b1);
    wait_boundary("mid_next_frame");
    measure_frame(h);
    check("mid_new_highs", h, 32'd10);

    // BLINK 2 on / 3 off; unused write bits are dropped.
    bus_write(2'd2, 32'd255);
    bus_write(2'd3, 32'hABCD_0201);
    read_check("rd_blink", 2'd3, 32'h0201);
    wait_boundary("blink_prep");
    bus_write(2'd0, 32'd2);
    wait_level(1'b0, "blink_fall");
    run_len(1'b0, len);
    check("blink_off_run", len, 32'd768);
    run_len(1'b1, len);
    check("blink_on_run", len, 32'd512);
    run_len(1'b0, len);
    check("blink_off_run2", len, 32'd768);

    // BREATHE with DUTY = 3, then clamp to DUTY = 1 on the up-slope.
    bus_write(2'd2, 32'd3);
    bus_write(2'd0, 32'd3);
    wait_boundary("breathe_entry");
    for (int i = 0; i < 10; i++) begin
      measure_frame(h);
      check($sformatf("breathe_f%0d", i), h, exp_breathe[i]);
    end
    measure_frame(h);
    check("breathe_f10", h, 32'd2);
    bus_write(2'd2, 32'd1);
    wait_boundary("clamp_frame");
    for (int i = 0; i < 4; i++) begin
      measure_frame(h);
      check($sformatf("clamp_f%0d", i), h, exp_clamp[i]);
    end

    // PRESCALE lowered below pcnt: tick next clock, then every 11 clocks.
    bus_write(2'd2, 32'd128);
    bus_write(2'd0, 32'd1);
    wait_boundary("presc_solid");
    bus_write(2'd1, 32'd1000);
    n = 0;
    while (m_pcnt != 499 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (m_pcnt != 499) timeout("presc_pcnt");
    bus_write(2'd1, 32'd10);
    read_check("rd_prescale", 2'd1, 32'd10);
    wait_level(1'b0, "presc_fall");
    wait_level(1'b1, "presc_rise");
    run_len(1'b1, len);
    check("presc_high_run", len, 32'd1408);
    run_len(1'b0, len);
    check("presc_low_run", len, 32'd1408);

    // OFF: active and pwm_out drop from the next frame.
    bus_write(2'd0, 32'd0);
    wait_boundary("off_frame");
    repeat (2) @(negedge clk);
    check("off_active", active, 1'b0);
    check("off_pwm", pwm_out, 1'b0);
    read_check("rd_mode_off", 2'd0, 32'd0);
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
